// File: rtl/score_display_pkg.sv
// score_display_pkg: shared states, segment codes and BCD helper for the score display path.
package score_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  localparam int DIGITS = 4;
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Double-dabble correction: any digit >= 5 gets +3 so the following shift carries correctly.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction
endpackage

// File: rtl/score_display_driver_seg7_decode.sv
// seg7_decode: 4-bit code to active-low {g,f,e,d,c,b,a}; codes above 9 blank the digit.
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (code_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/score_display_driver.sv
// score_display_driver: iterative binary-to-BCD converter driving four score digits and a mode digit.
module score_display_driver
  import score_display_pkg::*;
#(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value_in,
  input  logic             value_valid,
  output logic             value_ready,
  input  logic [1:0]       mode_in,
  input  logic             blank_lz,
  output logic             busy,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [6:0]       hex5
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d;
  logic b3, b2, b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q <= '0;
      disp_q <= '0;
      cnt_q <= '0;
      mode_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q <= bcd_d;
      disp_q <= disp_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
    end
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d = bcd_q;
    disp_d = disp_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    case (state_q)
      IDLE: if (value_valid) begin
        state_d = SHIFT;
        shift_d = value_in;
        mode_d = mode_in;
        bcd_d = '0;
        cnt_d = '0;
      end
      SHIFT: begin
        {bcd_d, shift_d} = {add3(bcd_q), shift_q} << 1;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : SHIFT;
      end
      DONE: begin
        disp_d = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign value_ready = (state_q == IDLE);
  assign busy = (state_q != IDLE);
  // Blanking propagates downward: a digit blanks only if every more significant digit is blank too.
  assign b3 = blank_lz && (disp_q[15:12] == 4'd0);
  assign b2 = b3 && (disp_q[11:8] == 4'd0);
  assign b1 = b2 && (disp_q[7:4] == 4'd0);
  seg7_decode u_hex0 (.code_i(disp_q[3:0]), .seg_o(hex0));
  seg7_decode u_hex1 (.code_i(b1 ? 4'hF : disp_q[7:4]), .seg_o(hex1));
  seg7_decode u_hex2 (.code_i(b2 ? 4'hF : disp_q[11:8]), .seg_o(hex2));
  seg7_decode u_hex3 (.code_i(b3 ? 4'hF : disp_q[15:12]), .seg_o(hex3));
  seg7_decode u_hex5 (.code_i({3'b000, mode_q[0]}), .seg_o(hex5));
endmodule

// File: doc/score_display_driver.md
# score_display_driver

Sequential display back-end for the score path: accepts a binary score word over a valid/ready handshake, converts it to four BCD digits with a multi-cycle shift-and-add-3 (double-dabble) engine, and drives four active-low seven-segment digits plus a mode digit. It sits between the score/high-score logic and the HEX display pins. It replaces combinational divide/modulo digit extraction with a small, timing-friendly iterative converter.

## Interface
- WIDTH, 11, binary score width; legal range 4..13 (so the result always fits 4 decimal digits).
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- value_in  input  WIDTH  binary score to display.
- value_valid  input  1  value_in is presented.
- value_ready  output  1  block can accept; high only in IDLE.
- mode_in  input  2  display mode, captured with value_in.
- blank_lz  input  1  when high, leading-zero digits on hex3..hex1 are blanked.
- busy  output  1  conversion in progress (SHIFT or DONE).
- hex0  output  7  ones digit, segments {g,f,e,d,c,b,a}, active-low.
- hex1  output  7  tens digit.
- hex2  output  7  hundreds digit.
- hex3  output  7  thousands digit.
- hex5  output  7  mode digit: shows mode_in[0] as 0 or 1.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: value_ready=1. On value_valid & value_ready: capture value_in into shift register, capture mode_in into mode_q, clear BCD scratch (16 bits), iteration count=0, go to SHIFT.
- SHIFT: per cycle, each 4-bit scratch digit ≥5 gets +3, then {scratch, shift} shifts left one bit. Count increments; after WIDTH iterations go to DONE.
- DONE: copy scratch into display digit registers d3..d0; go to IDLE.
- value_valid while not in IDLE is ignored; source holds until handshake. value_in changes after capture have no effect.
- Segment map (active-low): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; any other code = 7'h7F (blank).
- Blanking (combinational from registered digits and blank_lz): hex3 blank if d3=0; hex2 blank if d3=d2=0; hex1 blank if d3=d2=d1=0. hex0 never blanked.
- hex5 = segment code of {3'b0, mode_q[0]}.
- Reset values: state IDLE, value_ready=1, busy=0, d3..d0=0, mode_q=0; hex0=7'h40, hex5=7'h40, hex1..hex3=7'h40 if blank_lz=0 else 7'h7F.
- Reset asserted mid-conversion aborts immediately; displayed value returns to 0 and the pending value is lost.

## Timing
- Handshake at edge T; SHIFT occupies edges T+1..T+WIDTH; display registers update at edge T+WIDTH+1 (T+12 at WIDTH=11), same edge state returns to IDLE.
- value_ready low from T+1 through T+WIDTH+1 inclusive; next accept possible at edge T+WIDTH+2. Throughput one value per WIDTH+2 cycles.
- Displayed digits stay stable (old value) for the entire conversion; no partial values ever reach hex outputs.
- hex5 updates at T+1 (mode_q captured at handshake), ahead of digits by design.
- blank_lz is combinational to hex1..hex3; no latency.

## Structure
- Package score_display_pkg: state enum (IDLE/SHIFT/DONE), DIGITS=4, segment constants SEG_0..SEG_9 and SEG_BLANK.
- Sub-module seg7_decode: 4-bit code in, 7-bit active-low segments out, pure combinational; instantiated five times (hex0..hex3, hex5). Blanking muxing stays in the top.

## Test plan
- Reset, no input -> hex0=7'h40, hex5=7'h40, hex1..3=7'h40 (blank_lz=0) and 7'h7F (blank_lz=1); value_ready=1, busy=0.
- value_in=2047, mode_in=1 -> digits 2,0,4,7 (hex3..hex0 = 7'h24,7'h40,7'h19,7'h78) exactly 12 edges after handshake; hex5=7'h79 one edge after.
- value_in=9, blank_lz=1 -> hex0=7'h10, hex1..3=7'h7F; toggle blank_lz=0 -> hex1..3=7'h40 same cycle.
- value_in=105, blank_lz=1 -> hex3 blank, hex2=7'h79, hex1=7'h40 (inner zero shown), hex0=7'h12.
- Back-to-back: hold value_valid with 37 then 500 -> second accepted at edge T+13; displays show 37 through 500's conversion, then 500; value_ready timing checked each cycle.
- Assert rst at T+5 during conversion of 1999 -> outputs return to reset values asynchronously; after release a new handshake of 8 shows 8 at 12 edges.
